seq_ctrl: RTL and testbench

Multi-cycle sequencer for the 8-bit accumulator CPU datapath: PC, instruction register, accumulator, ALU and a shared RAM that may insert wait states.
It runs fetch/decode/execute as a Moore/Mealy FSM and issues one-cycle enable strobes to the datapath.
It handshakes with memory over req/rdy, supports run and single-step control, and detects memory-access timeouts.
It replaces the single-cycle control path when memory latency exceeds one cycle.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/seq_wait_timer.sv | 40 ++++
 rtl/seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared opcodes, sequencer state encodings and datapath widths.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int c_addr_w = 5;
  localparam int c_data_w = 8;

  localparam logic [2:0] c_op_lda = 3'b000;
  localparam logic [2:0] c_op_sta = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;
  localparam logic [2:0] c_op_jmp = 3'b100;
  localparam logic [2:0] c_op_jz  = 3'b101;
  localparam logic [2:0] c_op_jc  = 3'b110;
  localparam logic [2:0] c_op_hlt = 3'b111;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEMWR  = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  function automatic logic is_access(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_wait_timer.sv
// ============================================================================
// Module  : seq_wait_timer
// Brief   : Memory wait-state counter with timeout detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_wait_timer #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WAIT_W-1:0] c_last = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry fires on the wait cycle that would bring the count up to TIMEOUT.
  if (TIMEOUT == 0) begin : g_no_timeout
    assign expired_o = 1'b0;
  end else begin : g_timeout
    assign expired_o = en_i && (r_cnt == c_last);
  end

endmodule

`default_nettype wire

// File: rtl/seq_ctrl.sv
// ============================================================================
// Module  : seq_ctrl
// Brief   : Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_ctrl
  import cpu_pkg::*;
#(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [2:0]       op_i,
  input  logic             flag_z_i,
  input  logic             flag_c_i,
  input  logic             mem_rdy_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_sel_o,
  output logic             ir_we_o,
  output logic             pc_inc_o,
  output logic             pc_load_o,
  output logic             acc_we_o,
  output logic             flags_we_o,
  output logic [2:0]       state_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_t             r_state;
  state_t             w_next;
  state_t             w_after;
  logic               r_step_d;
  logic               r_step_mode;
  logic               w_step_mode_nxt;
  logic               w_step_rise;
  logic               r_fault;
  logic               r_halted;
  logic [CNT_W-1:0]   r_instr_cnt;
  logic               w_retire;
  logic               w_access;
  logic               w_expired;

  assign w_step_rise = step_i && !r_step_d;
  assign w_access    = is_access(r_state);

  seq_wait_timer #(
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (!w_access || mem_rdy_i),
    .en_i      (w_access && !mem_rdy_i),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_HALT;
      r_step_d    <= 1'b0;
      r_step_mode <= 1'b0;
      r_fault     <= 1'b0;
      r_halted    <= 1'b1;
      r_instr_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_step_d    <= step_i;
      r_step_mode <= w_step_mode_nxt;
      r_fault     <= r_fault || (w_next == ST_FAULT);
      r_halted    <= (w_next == ST_HALT);
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_step_mode_nxt = r_step_mode;
    w_retire        = 1'b0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_sel_o       = 1'b0;
    ir_we_o         = 1'b0;
    pc_inc_o        = 1'b0;
    pc_load_o       = 1'b0;
    acc_we_o        = 1'b0;
    flags_we_o      = 1'b0;
    // Single-stepped instructions always return to HALT after retiring.
    w_after         = (run_i && !r_step_mode) ? ST_FETCH : ST_HALT;

    case (r_state)
      ST_HALT: begin
        if (run_i) begin
          w_next          = ST_FETCH;
          w_step_mode_nxt = 1'b0;
        end else if (w_step_rise) begin
          w_next          = ST_FETCH;
          w_step_mode_nxt = 1'b1;
        end
      end
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_rdy_i) begin
          ir_we_o  = 1'b1;
          pc_inc_o = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        case (op_i)
          c_op_lda, c_op_add, c_op_sub: w_next = ST_MEMRD;
          c_op_sta:                     w_next = ST_MEMWR;
          c_op_jmp, c_op_jz, c_op_jc:   w_next = ST_EXEC;
          default: begin
            w_retire = 1'b1;
            w_next   = ST_HALT;
          end
        endcase
      end
      ST_MEMRD: begin
        mem_req_o = 1'b1;
        mem_sel_o = 1'b1;
        if (mem_rdy_i) begin
          acc_we_o   = 1'b1;
          flags_we_o = 1'b1;
          w_retire   = 1'b1;
          w_next     = w_after;
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end
      end
      ST_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        mem_sel_o = 1'b1;
        if (mem_rdy_i) begin
          w_retire = 1'b1;
          w_next   = w_after;
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end
      end
      ST_EXEC: begin
        pc_load_o = (op_i == c_op_jmp) ||
                    ((op_i == c_op_jz) && flag_z_i) ||
                    ((op_i == c_op_jc) && flag_c_i);
        w_retire  = 1'b1;
        w_next    = w_after;
      end
      ST_FAULT: begin
        w_next = ST_FAULT;
      end
      default: begin
        w_next = ST_HALT;
      end
    endcase

    if (w_retire) begin
      w_step_mode_nxt = 1'b0;
    end
  end

  assign state_o     = r_state;
  assign halted_o    = r_halted;
  assign fault_o     = r_fault;
  assign instr_cnt_o = r_instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seq_ctrl.sv
// ============================================================================
// Module  : tb_seq_ctrl
// Brief   : Self-checking bench for seq_ctrl with a wait-state memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_ctrl;

  localparam logic [2:0] c_halt = 3'd0, c_fetch = 3'd1, c_decode = 3'd2, c_memrd = 3'd3,
                         c_exec = 3'd4, c_memwr = 3'd5, c_fault = 3'd6;
  localparam logic [2:0] c_lda = 3'b000, c_sta = 3'b001, c_add = 3'b010,
                         c_jmp = 3'b100, c_jz = 3'b101, c_jc = 3'b110, c_hlt = 3'b111;
  // Strobe order: req, we, sel, ir_we, pc_inc, pc_load, acc_we, flags_we.
  localparam logic [7:0] c_sb_0 = 8'h00, c_sb_frdy = 8'h98, c_sb_fwait = 8'h80,
                         c_sb_rrdy = 8'hA3, c_sb_rwait = 8'hA0, c_sb_wr = 8'hE0,
                         c_sb_load = 8'h04;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0, run_i = 1'b0, step_i = 1'b0;
  logic       flag_z_i = 1'b0, flag_c_i = 1'b0;
  logic [2:0] op_i = 3'b000;
  logic       mem_rdy_i;
  logic       mem_req_o, mem_we_o, mem_sel_o, ir_we_o, pc_inc_o, pc_load_o;
  logic       acc_we_o, flags_we_o, halted_o, fault_o;
  logic [2:0] state_o;
  logic [7:0] instr_cnt_o;
  logic [7:0] strb;

  seq_ctrl #(.WAIT_W(4), .TIMEOUT(15), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .step_i(step_i), .op_i(op_i),
    .flag_z_i(flag_z_i), .flag_c_i(flag_c_i), .mem_rdy_i(mem_rdy_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .ir_we_o(ir_we_o), .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o),
    .acc_we_o(acc_we_o), .flags_we_o(flags_we_o), .state_o(state_o),
    .halted_o(halted_o), .fault_o(fault_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk = ~clk;

  assign strb = {mem_req_o, mem_we_o, mem_sel_o, ir_we_o, pc_inc_o, pc_load_o, acc_we_o, flags_we_o};

  // Memory / IR / PC model: rdy after wait_cfg stalled cycles of a request.
  logic [2:0] prog [32];
  logic [4:0] pc = 5'd0;
  logic       pc_clr = 1'b0, rdy_force = 1'b0, stall_wr = 1'b0;
  int         wait_cfg = 0, req_cnt = 0, n_inc = 0, n_load = 0;

  assign mem_rdy_i = rdy_force || (mem_req_o && (req_cnt >= wait_cfg) && !(stall_wr && mem_we_o));

  always @(posedge clk) begin
    req_cnt <= (mem_req_o && !mem_rdy_i) ? req_cnt + 1 : 0;
    if (pc_clr) begin
      pc     <= 5'd0;
      n_inc  <= 0;
      n_load <= 0;
    end else begin
      if (ir_we_o) op_i <= prog[pc];
      if (pc_load_o) begin
        pc     <= 5'd0;
        n_load <= n_load + 1;
      end else if (pc_inc_o) begin
        pc    <= pc + 5'd1;
        n_inc <= n_inc + 1;
      end
    end
  end

  typedef struct packed {logic [2:0] st; logic [7:0] sb;} exp_t;
  typedef struct {logic [2:0] op; logic z; logic c; logic load;} jvec_t;

  exp_t  exp_q[$];
  jvec_t jtab [7];
  int    n_tests = 0, n_fail = 0, trace_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [7:0] sb, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({st, sb});
  endtask

  // One clock: scoreboard compare at the falling edge, then settle after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (state_o !== e.st || strb !== e.sb) begin
        n_fail++;
        $display("FAIL trace[%0d]: state=%0d strobes=%h, expected state=%0d strobes=%h",
                 trace_idx, state_o, strb, e.st, e.sb);
      end
      trace_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic load_prog0(input logic [2:0] op);
    prog[0] = op;
    pc_clr  = 1'b1;
    tick();
    pc_clr  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) prog[i] = c_jmp;
    jtab[0] = '{c_jz,  1'b0, 1'b0, 1'b0};
    jtab[1] = '{c_jz,  1'b1, 1'b0, 1'b1};
    jtab[2] = '{c_jc,  1'b0, 1'b1, 1'b1};
    jtab[3] = '{c_jc,  1'b1, 1'b0, 1'b0};
    jtab[4] = '{c_jmp, 1'b0, 1'b0, 1'b1};
    jtab[5] = '{c_jz,  1'b0, 1'b1, 1'b0};
    jtab[6] = '{c_jmp, 1'b1, 1'b1, 1'b1};

    // Power-on reset
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 32'(c_halt));
    chk("rst_halted", 32'(halted_o), 32'd1);
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_cnt", 32'(instr_cnt_o), 32'd0);
    rst_i = 1'b1;
    tick();

    // rdy outside an access is ignored
    rdy_force = 1'b1;
    push(c_halt, c_sb_0, 4);
    drain();

    // LDA; ADD; STA; HLT free-running with zero-wait memory
    prog[0] = c_lda; prog[1] = c_add; prog[2] = c_sta; prog[3] = c_hlt;
    pc_clr = 1'b1; tick(); pc_clr = 1'b0;
    push(c_halt, c_sb_0, 1);
    for (int i = 0; i < 2; i++) begin
      push(c_fetch, c_sb_frdy, 1); push(c_decode, c_sb_0, 1); push(c_memrd, c_sb_rrdy, 1);
    end
    push(c_fetch, c_sb_frdy, 1); push(c_decode, c_sb_0, 1); push(c_memwr, c_sb_wr, 1);
    push(c_fetch, c_sb_frdy, 1); push(c_decode, c_sb_0, 1); push(c_halt, c_sb_0, 2);
    run_i = 1'b1;
    repeat (10) tick();
    run_i = 1'b0;
    drain();
    rdy_force = 1'b0;
    chk("prog_cnt", 32'(instr_cnt_o), 32'd4);
    chk("prog_halted", 32'(halted_o), 32'd1);
    chk("prog_pc_inc", 32'(n_inc), 32'd4);

    // Reset while a stalled MEMRD holds mem_req_o
    load_prog0(c_lda);
    wait_cfg = 5;
    run_i = 1'b1;
    for (int i = 0; i < 40 && state_o != c_memrd; i++) tick();
    chk("reach_memrd", 32'(state_o), 32'(c_memrd));
    chk("memrd_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0; run_i = 1'b0;
    tick(); tick();
    chk("midrst_state", 32'(state_o), 32'(c_halt));
    chk("midrst_halted", 32'(halted_o), 32'd1);
    chk("midrst_strobes", 32'(strb), 32'd0);
    chk("midrst_cnt", 32'(instr_cnt_o), 32'd0);
    rst_i = 1'b1;
    tick();

    // Single step with 3 wait states on every access, step held high
    load_prog0(c_lda);
    wait_cfg = 3;
    push(c_halt, c_sb_0, 1);
    push(c_fetch, c_sb_fwait, 3); push(c_fetch, c_sb_frdy, 1); push(c_decode, c_sb_0, 1);
    push(c_memrd, c_sb_rwait, 3); push(c_memrd, c_sb_rrdy, 1); push(c_halt, c_sb_0, 4);
    step_i = 1'b1;
    drain();
    step_i = 1'b0;
    chk("step_cnt", 32'(instr_cnt_o), 32'd1);
    chk("step_pc_inc", 32'(n_inc), 32'd1);
    chk("step_halted", 32'(halted_o), 32'd1);

    // Conditional / unconditional jumps, one single-step each
    wait_cfg = 0;
    for (int k = 0; k < 7; k++) begin
      flag_z_i = jtab[k].z;
      flag_c_i = jtab[k].c;
      load_prog0(jtab[k].op);
      push(c_halt, c_sb_0, 1); push(c_fetch, c_sb_frdy, 1); push(c_decode, c_sb_0, 1);
      push(c_exec, jtab[k].load ? c_sb_load : c_sb_0, 1); push(c_halt, c_sb_0, 1);
      step_i = 1'b1;
      drain();
      step_i = 1'b0;
      chk($sformatf("jump%0d_load", k), 32'(n_load), 32'(jtab[k].load));
    end
    chk("jump_cnt", 32'(instr_cnt_o), 32'd8);

    // MEMWR never completes: fault after 15 wait cycles, sticky
    load_prog0(c_sta);
    stall_wr = 1'b1;
    push(c_halt, c_sb_0, 1); push(c_fetch, c_sb_frdy, 1); push(c_decode, c_sb_0, 1);
    push(c_memwr, c_sb_wr, 15); push(c_fault, c_sb_0, 3);
    step_i = 1'b1;
    drain();
    step_i = 1'b0;
    chk("fault_set", 32'(fault_o), 32'd1);
    run_i = 1'b1; tick(); tick(); run_i = 1'b0; tick(); run_i = 1'b1; tick();
    chk("fault_state", 32'(state_o), 32'(c_fault));
    chk("fault_sticky", 32'(fault_o), 32'd1);
    chk("fault_strobes", 32'(strb), 32'd0);
    chk("fault_cnt", 32'(instr_cnt_o), 32'd8);
    run_i = 1'b0; stall_wr = 1'b0;
    rst_i = 1'b0; tick(); rst_i = 1'b1; tick();
    chk("fault_cleared", 32'(fault_o), 32'd0);

    // rdy on the 15th cycle of an access completes it without a fault
    load_prog0(c_sta);
    wait_cfg = 14;
    push(c_halt, c_sb_0, 1); push(c_fetch, c_sb_fwait, 14); push(c_fetch, c_sb_frdy, 1);
    push(c_decode, c_sb_0, 1); push(c_memwr, c_sb_wr, 15); push(c_halt, c_sb_0, 2);
    step_i = 1'b1;
    drain();
    step_i = 1'b0;
    chk("late_rdy_fault", 32'(fault_o), 32'd0);
    chk("late_rdy_cnt", 32'(instr_cnt_o), 32'd1);

    // Retired-instruction counter wraps from 255 to 0
    load_prog0(c_jmp);
    wait_cfg = 0;
    run_i = 1'b1;
    for (int i = 0; i < 1000 && instr_cnt_o != 8'd255; i++) tick();
    chk("cnt_255", 32'(instr_cnt_o), 32'd255);
    for (int i = 0; i < 10 && instr_cnt_o != 8'd0; i++) tick();
    chk("cnt_wrap", 32'(instr_cnt_o), 32'd0);
    run_i = 1'b0;
    for (int i = 0; i < 10 && !halted_o; i++) tick();
    chk("wrap_halted", 32'(halted_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
